array_index_pipe: RTL and testbench



---
 rtl/array_index_pipe.sv | 142 ++++++++++++++
 tb/tb_array_index_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/array_index_pipe.sv
// Pipelined, parametrised array indexer: selects arr[sel + OFFSET] through STAGES
// register stages with a valid/ready handshake and selectable out-of-range policy.
module array_index_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned OFFSET   = 1,
  parameter int unsigned OOB_MODE = 0,
  parameter int unsigned STAGES   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DEPTH*WIDTH-1:0] arr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic                   out_oob
);

  localparam int unsigned IW = SEL_W + 1;

  logic [IW-1:0]          w_idx_in;
  logic                   w_oob_in;
  logic [STAGES-1:0]      r_valid;
  logic [STAGES-1:0]      w_adv;
  logic [STAGES-1:0]      w_load;
  logic [IW-1:0]          w_fin_idx;
  logic                   w_fin_oob;
  logic [DEPTH*WIDTH-1:0] w_fin_arr;
  logic [31:0]            w_eff;
  logic [WIDTH-1:0]       w_data;
  logic [WIDTH-1:0]       r_out;
  logic                   r_out_oob;

  assign w_idx_in = {1'b0, sel} + IW'(OFFSET);
  assign w_oob_in = 32'(w_idx_in) >= DEPTH;

  // Ready ripples from out_ready back to stage 0: a stage may take new data
  // when it is empty or its own contents move on this cycle.
  always_comb begin
    logic        v_go;
    int unsigned k;
    v_go  = out_ready;
    w_adv = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      k        = STAGES - 1 - j;
      w_adv[k] = r_valid[k] & v_go;
      v_go     = ~r_valid[k] | v_go;
    end
    in_ready = v_go;
  end

  always_comb begin
    w_load    = w_adv << 1;
    w_load[0] = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (w_load[k])     r_valid[k] <= 1'b1;
        else if (w_adv[k]) r_valid[k] <= 1'b0;
      end
    end
  end

  // Non-final stages carry the computed index, its oob flag and the captured array.
  for (genvar g = 0; g < STAGES - 1; g++) begin : g_mid
    logic [IW-1:0]          r_idx;
    logic                   r_oob;
    logic [DEPTH*WIDTH-1:0] r_arr;
    logic [IW-1:0]          w_idx;
    logic                   w_oob;
    logic [DEPTH*WIDTH-1:0] w_arr;

    if (g == 0) begin : g_src
      assign w_idx = w_idx_in;
      assign w_oob = w_oob_in;
      assign w_arr = arr;
    end else begin : g_src
      assign w_idx = g_mid[g-1].r_idx;
      assign w_oob = g_mid[g-1].r_oob;
      assign w_arr = g_mid[g-1].r_arr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_idx <= '0;
        r_oob <= 1'b0;
        r_arr <= '0;
      end else if (w_load[g]) begin
        r_idx <= w_idx;
        r_oob <= w_oob;
        r_arr <= w_arr;
      end
    end
  end

  if (STAGES == 1) begin : g_fin
    assign w_fin_idx = w_idx_in;
    assign w_fin_oob = w_oob_in;
    assign w_fin_arr = arr;
  end else begin : g_fin
    assign w_fin_idx = g_mid[STAGES-2].r_idx;
    assign w_fin_oob = g_mid[STAGES-2].r_oob;
    assign w_fin_arr = g_mid[STAGES-2].r_arr;
  end

  // Wrap uses a true modulo so non-power-of-two depths behave correctly.
  always_comb begin
    case (OOB_MODE)
      1:       w_eff = 32'(w_fin_idx);
      2:       w_eff = 32'(w_fin_idx) % DEPTH;
      default: w_eff = w_fin_oob ? DEPTH - 1 : 32'(w_fin_idx);
    endcase
    w_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_eff == i) w_data = w_fin_arr[i*WIDTH +: WIDTH];
    end
    if (OOB_MODE == 1 && w_fin_oob) w_data = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_oob <= 1'b0;
    end else if (w_load[STAGES-1]) begin
      r_out     <= w_data;
      r_out_oob <= w_fin_oob;
    end
  end

  assign out       = r_out;
  assign out_oob   = r_out_oob;
  assign out_valid = r_valid[STAGES-1];

endmodule

// File: tb/tb_array_index_pipe.sv
// Scoreboard bench for array_index_pipe: four instances (clamp, zero, wrap, and
// wrap with DEPTH=3) share one stimulus stream and are checked against a model.
module tb_array_index_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   sel = '0;
  logic [127:0] arr = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

  logic [3:0]  w_ir, w_ov, w_oo;
  logic [31:0] w_out [4];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  bit          lat_chk = 1'b1;

  typedef struct {
    logic [3:0][32:0] r;
    int unsigned      c;
  } ent_t;
  ent_t q[$];

  array_index_pipe #(.WIDTH(32), .DEPTH(4), .SEL_W(2), .OFFSET(1), .OOB_MODE(0), .STAGES(2)) u_clamp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ir[0]), .sel(sel), .arr(arr),
    .out_valid(w_ov[0]), .out_ready(out_ready), .out(w_out[0]), .out_oob(w_oo[0]));
  array_index_pipe #(.WIDTH(32), .DEPTH(4), .SEL_W(2), .OFFSET(1), .OOB_MODE(1), .STAGES(2)) u_zero (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ir[1]), .sel(sel), .arr(arr),
    .out_valid(w_ov[1]), .out_ready(out_ready), .out(w_out[1]), .out_oob(w_oo[1]));
  array_index_pipe #(.WIDTH(32), .DEPTH(4), .SEL_W(2), .OFFSET(1), .OOB_MODE(2), .STAGES(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ir[2]), .sel(sel), .arr(arr),
    .out_valid(w_ov[2]), .out_ready(out_ready), .out(w_out[2]), .out_oob(w_oo[2]));
  array_index_pipe #(.WIDTH(32), .DEPTH(3), .SEL_W(2), .OFFSET(1), .OOB_MODE(2), .STAGES(2)) u_wrap3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ir[3]), .sel(sel), .arr(arr[95:0]),
    .out_valid(w_ov[3]), .out_ready(out_ready), .out(w_out[3]), .out_oob(w_oo[3]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [127:0] a, input logic [1:0] s,
                                        input int unsigned depth, input int unsigned mode);
    int unsigned idx, e;
    logic        o;
    logic [31:0] d;
    idx = 32'(s) + 1;
    o   = idx >= depth;
    case (mode)
      0:       e = o ? depth - 1 : idx;
      2:       e = idx % depth;
      default: e = idx;
    endcase
    d = (e < depth) ? a[e*32 +: 32] : 32'h0;
    if (mode == 1 && o) d = 32'h0;
    return {o, d};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (w_ov[0] && out_ready) begin
        if (q.size() == 0) begin
          chk("stale_out", w_ov[0], 0);
        end else begin
          ent_t e;
          e = q.pop_front();
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid%0d", i), w_ov[i], 1);
            chk($sformatf("out%0d", i), w_out[i], e.r[i][31:0]);
            chk($sformatf("oob%0d", i), w_oo[i], e.r[i][32]);
          end
          if (lat_chk) chk("latency", cyc - e.c, 2);
        end
      end
      if (in_valid && w_ir[0]) begin
        ent_t n;
        n.r[0] = model(arr, sel, 4, 0);
        n.r[1] = model(arr, sel, 4, 1);
        n.r[2] = model(arr, sel, 4, 2);
        n.r[3] = model(arr, sel, 3, 2);
        n.c    = cyc;
        q.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input bit must_rdy);
    bit ok;
    bit first;
    ok       = 1'b0;
    first    = 1'b1;
    in_valid = 1'b1;
    sel      = s;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = w_ir[0];
      if (must_rdy && first) chk("in_ready_b2b", w_ir[0], 1);
      first = 1'b0;
      tick();
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", q.size(), 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", w_ir[0], 1);
    chk("rst_out_valid", w_ov, 4'b0000);
    chk("rst_out", w_out[0], 0);
    chk("rst_oob", w_oo, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // latency and basic selection
    lat_chk = 1'b1;
    send(2'd1, 1'b0);
    drain();
    send(2'd0, 1'b0);
    drain();

    // out-of-range in every mode
    send(2'd3, 1'b0);
    drain();

    // back-to-back at full throughput
    for (int s = 0; s < 4; s++) send(2'(s), 1'b1);
    drain();

    // backpressure: two fill the pipe, the third waits
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    in_valid = 1'b1;
    sel      = 2'd2;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", w_ir[0], 0);
      chk("bp_valid", w_ov[0], 1);
      chk("bp_hold_out", w_out[0], 32'hBBBB_BBBB);
      chk("bp_hold_oob", w_oo[0], 0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_while_drain", w_ir[0], 1);
    tick();
    in_valid = 1'b0;
    drain();

    // array captured at accept, later changes ignored
    lat_chk = 1'b1;
    send(2'd1, 1'b0);
    arr[95:64] = 32'h1234_5678;
    drain();
    arr[95:64] = 32'hCCCC_CCCC;

    // reset with requests in flight
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_valid", w_ov, 4'b0000);
    chk("midrst_out", w_out[0], 0);
    chk("midrst_oob", w_oo[0], 0);
    chk("midrst_in_ready", w_ir[0], 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", w_ov[0], 0);
    end
    tick();
    send(2'd2, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
